// File: rtl/psec5_readout_pkg.sv
// Shared definitions for the readout serializer.
// Holds the control FSM state type, the default channel and word counts,
// and the width of one stored word.
package psec5_readout_pkg;

    localparam int NCH_DEF    = 8;
    localparam int NWORDS_DEF = 8;
    localparam int WORD_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } rs_state_e;

endpackage

// File: rtl/lane_shreg.sv
// Single-lane word register: parallel load, right shift, LSB out.
// Ports:
//   i_clk   - clock
//   i_clr   - synchronous clear, highest priority
//   i_load  - capture i_d
//   i_shift - shift right by one, zero fill from the top
//   i_d     - parallel word
//   o_bit   - current serial bit (register bit 0)
module lane_shreg
    import psec5_readout_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_d,
    output logic              o_bit
);

    logic [WORD_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_shift) begin
            r_q <= {1'b0, r_q[WORD_W-1:1]};
        end
    end

    assign o_bit = r_q[0];

endmodule

// File: rtl/readout_serializer.sv
// Multi-lane readout serializer.
// On a rising inst_readout it streams NWORDS words per channel, LSB first,
// one serial lane per channel, with no gap between words, then pulses done.
// Ports:
//   sclk           - clock
//   rst            - synchronous active-high reset
//   inst_readout   - readout request level (edge detected)
//   inst_rst       - synchronous abort
//   word_data      - per-channel word selected by load_cnt_ser
//   load_cnt_ser   - one-hot word select to channel storage
//   raw_serial_out - per-channel serial bit
//   busy           - readout in progress
//   done           - one-cycle pulse after the final bit
module readout_serializer
    import psec5_readout_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int NWORDS = NWORDS_DEF
)
(
    input  logic                          sclk,
    input  logic                          rst,
    input  logic                          inst_readout,
    input  logic                          inst_rst,
    input  logic [NCH-1:0][WORD_W-1:0]    word_data,
    output logic [NWORDS-1:0]             load_cnt_ser,
    output logic [NCH-1:0]                raw_serial_out,
    output logic                          busy,
    output logic                          done
);

    localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);

    rs_state_e          r_state;
    logic               r_req_d;
    logic [2:0]         r_bit_cnt;
    logic [WCW-1:0]     r_word_cnt;
    logic [NWORDS-1:0]  r_load_sel;
    logic               r_busy;
    logic               r_done;

    logic               w_req_rise;
    logic               w_last_bit;
    logic               w_load;
    logic               w_shift;
    logic               w_clr;
    logic [NCH-1:0]     w_lane_bit;

    assign w_req_rise = inst_readout & ~r_req_d;
    assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == 3'd7);
    // Lanes capture on the LOAD exit edge and on every word boundary except
    // the last, so the next word follows the previous one without a gap.
    assign w_load     = (r_state == LOAD) || (w_last_bit && (r_word_cnt != LAST_WORD));
    assign w_shift    = (r_state == SHIFT) && !w_load;
    assign w_clr      = rst | inst_rst;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        lane_shreg u_lane (
            .i_clk   (sclk),
            .i_clr   (w_clr),
            .i_load  (w_load),
            .i_shift (w_shift),
            .i_d     (word_data[g]),
            .o_bit   (w_lane_bit[g])
        );
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req_d    <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_load_sel <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // History always tracks the level, so a request held through an
            // abort or a busy period never starts a readout later.
            r_req_d <= inst_readout;
            if (inst_rst) begin
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_load_sel <= '0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_req_rise) begin
                            r_state    <= LOAD;
                            r_load_sel <= NWORDS'(1);
                            r_busy     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        r_state    <= SHIFT;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        // Pre-select word 1 so it is ready at the first boundary.
                        r_load_sel <= (LAST_WORD == '0) ? '0 : (r_load_sel << 1);
                    end
                    SHIFT: begin
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            if (r_word_cnt == LAST_WORD) begin
                                r_state    <= DONE;
                                r_word_cnt <= '0;
                                r_done     <= 1'b1;
                            end else begin
                                r_word_cnt <= r_word_cnt + WCW'(1);
                                // Nothing left to pre-select once the last word is loaded.
                                r_load_sel <= (r_word_cnt + WCW'(1) == LAST_WORD) ?
                                              '0 : (r_load_sel << 1);
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign load_cnt_ser   = r_load_sel;
    assign raw_serial_out = (r_state == SHIFT) ? w_lane_bit : '0;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_readout_serializer.sv
module tb_readout_serializer;

    localparam int NCH = 8;
    localparam int NW  = 8;
    localparam int LEN = 8 * NW;

    logic                  sclk = 1'b0;
    logic                  rst;
    logic                  inst_readout;
    logic                  inst_rst;
    logic [NCH-1:0][7:0]   word_data;
    logic [NW-1:0]         load_cnt_ser;
    logic [NCH-1:0]        raw_serial_out;
    logic                  busy;
    logic                  done;

    logic [7:0] mem [NW][NCH];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  n_done = 0;
    bit  m_act  = 0;

    always #5 sclk = ~sclk;

    readout_serializer #(.NCH(NCH), .NWORDS(NW)) dut (
        .sclk           (sclk),
        .rst            (rst),
        .inst_readout   (inst_readout),
        .inst_rst       (inst_rst),
        .word_data      (word_data),
        .load_cnt_ser   (load_cnt_ser),
        .raw_serial_out (raw_serial_out),
        .busy           (busy),
        .done           (done)
    );

    // Channel storage: returns the word picked by the one-hot select.
    always_comb begin
        word_data = '0;
        for (int w = 0; w < NW; w++)
            if (load_cnt_ser[w])
                for (int c = 0; c < NCH; c++) word_data[c] = word_data[c] | mem[w][c];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: a readout is a timeline offset t from the request edge.
    // t=0 word-0 select, t=1..LEN stream bit t-1, t=LEN+1 done, then idle.
    initial begin
        bit prev = 0;
        int t = 0;
        bit r, ir, rd;
        logic [NW-1:0]  e_sel;
        logic [NCH-1:0] e_raw;
        logic           e_busy, e_done;
        forever begin
            @(posedge sclk);
            r = rst; ir = inst_rst; rd = inst_readout;
            if (r) begin
                m_act = 0; prev = 0;
            end else begin
                if (ir) m_act = 0;
                else if (m_act) begin
                    t++;
                    if (t > LEN + 1) m_act = 0;
                end else if (rd && !prev) begin
                    m_act = 1; t = 0;
                end
                prev = rd;
            end
            #1;
            e_sel = '0; e_raw = '0; e_busy = 0; e_done = 0;
            if (m_act) begin
                e_busy = 1;
                if (t == 0) e_sel[0] = 1'b1;
                else if (t <= LEN) begin
                    int w, b;
                    w = (t - 1) / 8;
                    b = (t - 1) % 8;
                    if (w < NW - 1) e_sel[w+1] = 1'b1;
                    for (int c = 0; c < NCH; c++) e_raw[c] = mem[w][c][b];
                end else e_done = 1;
            end
            chk("load_cnt_ser", 64'(load_cnt_ser), 64'(e_sel));
            chk("raw_serial_out", 64'(raw_serial_out), 64'(e_raw));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            if (done === 1'b1) n_done++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic settle();
        inst_readout = 0; inst_rst = 0; rst = 0;
        for (int i = 0; i < 100 && m_act; i++) cyc(1);
        chk("settle_idle", 64'(m_act), 64'(0));
        cyc(2);
    endtask

    initial begin
        logic [7:0] cap [NW][NCH];
        logic [7:0] lit [NCH];
        int d0;
        rst = 1; inst_readout = 0; inst_rst = 0;
        for (int w = 0; w < NW; w++)
            for (int c = 0; c < NCH; c++) mem[w][c] = 8'($urandom);
        cyc(3);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_sel", 64'(load_cnt_ser), 64'(0));
        chk("reset_raw", 64'(raw_serial_out), 64'(0));
        rst = 0;
        cyc(2);

        // Basic readout: word k = 0x33+k on every channel.
        for (int w = 0; w < NW; w++)
            for (int c = 0; c < NCH; c++) mem[w][c] = 8'(8'h33 + w);
        d0 = n_done;
        inst_readout = 1;
        cyc(1);
        chk("basic_load_busy", 64'(busy), 64'(1));
        chk("basic_load_sel", 64'(load_cnt_ser), 64'h01);
        inst_readout = 0;
        for (int i = 0; i < LEN; i++) begin
            cyc(1);
            for (int c = 0; c < NCH; c++) cap[i/8][c][i%8] = raw_serial_out[c];
        end
        cyc(1);
        chk("basic_done", 64'(done), 64'(1));
        cyc(1);
        chk("basic_idle_busy", 64'(busy), 64'(0));
        for (int w = 0; w < NW; w++)
            for (int c = 0; c < NCH; c++) chk("basic_byte", 64'(cap[w][c]), 64'(8'h33 + w));
        chk("basic_done_count", 64'(n_done - d0), 64'(1));

        // Lane independence.
        lit = '{8'h29, 8'hA9, 8'h36, 8'h07, 8'h00, 8'h01, 8'h04, 8'hFF};
        for (int c = 0; c < NCH; c++) mem[0][c] = lit[c];
        inst_readout = 1;
        cyc(1);
        inst_readout = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            for (int c = 0; c < NCH; c++) cap[0][c][i] = raw_serial_out[c];
        end
        for (int c = 0; c < NCH; c++) chk("lane_byte0", 64'(cap[0][c]), 64'(lit[c]));
        settle();

        // Held request: one stream only.
        d0 = n_done;
        inst_readout = 1;
        cyc(200);
        inst_readout = 0;
        cyc(5);
        chk("held_done_count", 64'(n_done - d0), 64'(1));
        chk("held_idle", 64'(busy), 64'(0));

        // Abort at bit 20, then a fresh full stream.
        d0 = n_done;
        inst_readout = 1; cyc(1); inst_readout = 0;
        cyc(21);
        inst_rst = 1; cyc(1); inst_rst = 0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_raw", 64'(raw_serial_out), 64'(0));
        chk("abort_sel", 64'(load_cnt_ser), 64'(0));
        cyc(70);
        chk("abort_no_done", 64'(n_done - d0), 64'(0));
        inst_readout = 1; cyc(1); inst_readout = 0;
        cyc(LEN + 3);
        chk("abort_restart_done", 64'(n_done - d0), 64'(1));

        // Reset at bit 40.
        d0 = n_done;
        inst_readout = 1; cyc(1); inst_readout = 0;
        cyc(41);
        rst = 1; cyc(1); rst = 0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_raw", 64'(raw_serial_out), 64'(0));
        chk("rst_sel", 64'(load_cnt_ser), 64'(0));
        cyc(40);
        chk("rst_no_done", 64'(n_done - d0), 64'(0));

        // inst_rst together with a request rise.
        inst_rst = 1; inst_readout = 1; cyc(1); inst_rst = 0;
        chk("simul_busy", 64'(busy), 64'(0));
        cyc(5);
        chk("simul_still_idle", 64'(busy), 64'(0));
        inst_readout = 0; cyc(2);

        // Re-rise during SHIFT is ignored.
        d0 = n_done;
        inst_readout = 1; cyc(1); inst_readout = 0;
        cyc(10); inst_readout = 1; cyc(1); inst_readout = 0;
        cyc(LEN + 10);
        chk("ignored_done_count", 64'(n_done - d0), 64'(1));
        chk("ignored_idle", 64'(busy), 64'(0));

        // Randomized traffic against the reference.
        for (int it = 0; it < 5; it++) begin
            settle();
            for (int w = 0; w < NW; w++)
                for (int c = 0; c < NCH; c++) mem[w][c] = 8'($urandom);
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(7, 0) == 0) inst_readout = ~inst_readout;
                inst_rst = ($urandom_range(79, 0) == 0);
                rst      = ($urandom_range(299, 0) == 0);
                cyc(1);
            end
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
